// File: rtl/qpu_itcm_arbiter.sv
// qpu_itcm_arbiter: shares the single ITCM ICB port between the IFU fetch path
// (read-only) and the host program-loader path (read/write).
//
// Commands pass straight through with no added latency. Grants alternate
// round-robin between the two requesters. Once a command is presented but not
// yet accepted, the grant stays locked to that requester so the ICB command
// remains stable. The requester ID of every accepted command goes into a small
// in-order FIFO, and the FIFO head steers each ITCM response back to its issuer.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   ifu_icb_cmd_*         IFU command channel (address only, always a read)
//   ifu_icb_rsp_*         IFU response channel
//   ldr_icb_cmd_*         loader command channel (addr/read/wdata/wmask)
//   ldr_icb_rsp_*         loader response channel
//   itcm_icb_cmd_*        muxed command channel to the ITCM
//   itcm_icb_rsp_*        response channel from the ITCM
//   arb_busy              commands outstanding, lock held, or a request pending
module qpu_itcm_arbiter #(
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned OUTS_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  ifu_icb_cmd_valid,
    output logic                  ifu_icb_cmd_ready,
    input  logic [ADDR_W-1:0]     ifu_icb_cmd_addr,
    output logic                  ifu_icb_rsp_valid,
    input  logic                  ifu_icb_rsp_ready,
    output logic                  ifu_icb_rsp_err,
    output logic [DATA_W-1:0]     ifu_icb_rsp_rdata,

    input  logic                  ldr_icb_cmd_valid,
    output logic                  ldr_icb_cmd_ready,
    input  logic [ADDR_W-1:0]     ldr_icb_cmd_addr,
    input  logic                  ldr_icb_cmd_read,
    input  logic [DATA_W-1:0]     ldr_icb_cmd_wdata,
    input  logic [DATA_W/8-1:0]   ldr_icb_cmd_wmask,
    output logic                  ldr_icb_rsp_valid,
    input  logic                  ldr_icb_rsp_ready,
    output logic                  ldr_icb_rsp_err,
    output logic [DATA_W-1:0]     ldr_icb_rsp_rdata,

    output logic                  itcm_icb_cmd_valid,
    input  logic                  itcm_icb_cmd_ready,
    output logic [ADDR_W-1:0]     itcm_icb_cmd_addr,
    output logic                  itcm_icb_cmd_read,
    output logic [DATA_W-1:0]     itcm_icb_cmd_wdata,
    output logic [DATA_W/8-1:0]   itcm_icb_cmd_wmask,
    input  logic                  itcm_icb_rsp_valid,
    output logic                  itcm_icb_rsp_ready,
    input  logic                  itcm_icb_rsp_err,
    input  logic [DATA_W-1:0]     itcm_icb_rsp_rdata,

    output logic                  arb_busy
);

    localparam int unsigned PTR_W = (OUTS_DEPTH > 1) ? $clog2(OUTS_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(OUTS_DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(OUTS_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(OUTS_DEPTH - 1);

    typedef enum logic {
        ReqIfu = 1'b0,
        ReqLdr = 1'b1
    } req_e;

    // Outstanding-ID FIFO: one bit per entry, set means the loader issued it.
    logic [OUTS_DEPTH-1:0] id_fifo_q, id_fifo_d;
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  lock_q, lock_d;
    req_e                  lock_id_q, lock_id_d;
    req_e                  last_grant_q, last_grant_d;

    logic not_full;
    logic fifo_empty;
    logic grant_vld;
    req_e grant_id;
    req_e head_id;
    logic cmd_push;
    logic rsp_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == LAST_PTR) begin
            return '0;
        end
        return p + PTR_W'(1);
    endfunction

    assign not_full   = (count_q != DEPTH_C);
    assign fifo_empty = (count_q == '0);
    assign head_id    = req_e'(id_fifo_q[rd_ptr_q]);

    // Grant selection: a pending lock wins, otherwise round-robin on ties.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = ReqIfu;
        if (lock_q) begin
            grant_vld = 1'b1;
            grant_id  = lock_id_q;
        end else if (ifu_icb_cmd_valid && ldr_icb_cmd_valid) begin
            grant_vld = 1'b1;
            grant_id  = (last_grant_q == ReqIfu) ? ReqLdr : ReqIfu;
        end else if (ifu_icb_cmd_valid) begin
            grant_vld = 1'b1;
            grant_id  = ReqIfu;
        end else if (ldr_icb_cmd_valid) begin
            grant_vld = 1'b1;
            grant_id  = ReqLdr;
        end
    end

    // Command mux. IFU commands are always plain reads.
    always_comb begin
        itcm_icb_cmd_valid = 1'b0;
        itcm_icb_cmd_addr  = '0;
        itcm_icb_cmd_read  = 1'b0;
        itcm_icb_cmd_wdata = '0;
        itcm_icb_cmd_wmask = '0;
        ifu_icb_cmd_ready  = 1'b0;
        ldr_icb_cmd_ready  = 1'b0;
        if (grant_vld) begin
            if (grant_id == ReqLdr) begin
                itcm_icb_cmd_valid = ldr_icb_cmd_valid && not_full;
                itcm_icb_cmd_addr  = ldr_icb_cmd_addr;
                itcm_icb_cmd_read  = ldr_icb_cmd_read;
                itcm_icb_cmd_wdata = ldr_icb_cmd_wdata;
                itcm_icb_cmd_wmask = ldr_icb_cmd_wmask;
                ldr_icb_cmd_ready  = itcm_icb_cmd_ready && not_full;
            end else begin
                itcm_icb_cmd_valid = ifu_icb_cmd_valid && not_full;
                itcm_icb_cmd_addr  = ifu_icb_cmd_addr;
                itcm_icb_cmd_read  = 1'b1;
                ifu_icb_cmd_ready  = itcm_icb_cmd_ready && not_full;
            end
        end
    end

    // Response routing from the FIFO head. An empty FIFO consumes nothing.
    always_comb begin
        ifu_icb_rsp_valid  = 1'b0;
        ifu_icb_rsp_err    = 1'b0;
        ifu_icb_rsp_rdata  = '0;
        ldr_icb_rsp_valid  = 1'b0;
        ldr_icb_rsp_err    = 1'b0;
        ldr_icb_rsp_rdata  = '0;
        itcm_icb_rsp_ready = 1'b0;
        if (!fifo_empty) begin
            if (head_id == ReqLdr) begin
                ldr_icb_rsp_valid  = itcm_icb_rsp_valid;
                ldr_icb_rsp_err    = itcm_icb_rsp_err;
                ldr_icb_rsp_rdata  = itcm_icb_rsp_rdata;
                itcm_icb_rsp_ready = ldr_icb_rsp_ready;
            end else begin
                ifu_icb_rsp_valid  = itcm_icb_rsp_valid;
                ifu_icb_rsp_err    = itcm_icb_rsp_err;
                ifu_icb_rsp_rdata  = itcm_icb_rsp_rdata;
                itcm_icb_rsp_ready = ifu_icb_rsp_ready;
            end
        end
    end

    assign cmd_push = itcm_icb_cmd_valid && itcm_icb_cmd_ready;
    assign rsp_pop  = itcm_icb_rsp_valid && itcm_icb_rsp_ready;
    assign arb_busy = !fifo_empty || lock_q || ifu_icb_cmd_valid || ldr_icb_cmd_valid;

    always_comb begin
        id_fifo_d    = id_fifo_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        last_grant_d = last_grant_q;
        lock_id_d    = lock_id_q;
        // Lock exactly while a presented command waits; the handshake clears it.
        lock_d       = itcm_icb_cmd_valid && !itcm_icb_cmd_ready;
        if (lock_d) begin
            lock_id_d = grant_id;
        end
        if (cmd_push) begin
            id_fifo_d[wr_ptr_q] = grant_id;
            wr_ptr_d            = ptr_inc(wr_ptr_q);
            last_grant_d        = grant_id;
        end
        if (rsp_pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        unique case ({cmd_push, rsp_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_fifo_q    <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            lock_q       <= 1'b0;
            lock_id_q    <= ReqIfu;
            last_grant_q <= ReqLdr;  // IFU wins the first tie
        end else begin
            id_fifo_q    <= id_fifo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            lock_q       <= lock_d;
            lock_id_q    <= lock_id_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: tb/tb_qpu_itcm_arbiter.sv
// Bench for qpu_itcm_arbiter: directed command stimulus on both requesters, a
// behavioural in-order ITCM, and per-requester response scoreboards.
module tb_qpu_itcm_arbiter;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                ifu_icb_cmd_valid, ifu_icb_cmd_ready;
    logic [ADDR_W-1:0]   ifu_icb_cmd_addr;
    logic                ifu_icb_rsp_valid, ifu_icb_rsp_ready, ifu_icb_rsp_err;
    logic [DATA_W-1:0]   ifu_icb_rsp_rdata;
    logic                ldr_icb_cmd_valid, ldr_icb_cmd_ready;
    logic [ADDR_W-1:0]   ldr_icb_cmd_addr;
    logic                ldr_icb_cmd_read;
    logic [DATA_W-1:0]   ldr_icb_cmd_wdata;
    logic [DATA_W/8-1:0] ldr_icb_cmd_wmask;
    logic                ldr_icb_rsp_valid, ldr_icb_rsp_ready, ldr_icb_rsp_err;
    logic [DATA_W-1:0]   ldr_icb_rsp_rdata;
    logic                itcm_icb_cmd_valid, itcm_icb_cmd_ready;
    logic [ADDR_W-1:0]   itcm_icb_cmd_addr;
    logic                itcm_icb_cmd_read;
    logic [DATA_W-1:0]   itcm_icb_cmd_wdata;
    logic [DATA_W/8-1:0] itcm_icb_cmd_wmask;
    logic                itcm_icb_rsp_valid, itcm_icb_rsp_ready, itcm_icb_rsp_err;
    logic [DATA_W-1:0]   itcm_icb_rsp_rdata;
    logic                arb_busy;

    always #5 clk = ~clk;

    qpu_itcm_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .OUTS_DEPTH (DEPTH)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .ifu_icb_cmd_valid  (ifu_icb_cmd_valid),
        .ifu_icb_cmd_ready  (ifu_icb_cmd_ready),
        .ifu_icb_cmd_addr   (ifu_icb_cmd_addr),
        .ifu_icb_rsp_valid  (ifu_icb_rsp_valid),
        .ifu_icb_rsp_ready  (ifu_icb_rsp_ready),
        .ifu_icb_rsp_err    (ifu_icb_rsp_err),
        .ifu_icb_rsp_rdata  (ifu_icb_rsp_rdata),
        .ldr_icb_cmd_valid  (ldr_icb_cmd_valid),
        .ldr_icb_cmd_ready  (ldr_icb_cmd_ready),
        .ldr_icb_cmd_addr   (ldr_icb_cmd_addr),
        .ldr_icb_cmd_read   (ldr_icb_cmd_read),
        .ldr_icb_cmd_wdata  (ldr_icb_cmd_wdata),
        .ldr_icb_cmd_wmask  (ldr_icb_cmd_wmask),
        .ldr_icb_rsp_valid  (ldr_icb_rsp_valid),
        .ldr_icb_rsp_ready  (ldr_icb_rsp_ready),
        .ldr_icb_rsp_err    (ldr_icb_rsp_err),
        .ldr_icb_rsp_rdata  (ldr_icb_rsp_rdata),
        .itcm_icb_cmd_valid (itcm_icb_cmd_valid),
        .itcm_icb_cmd_ready (itcm_icb_cmd_ready),
        .itcm_icb_cmd_addr  (itcm_icb_cmd_addr),
        .itcm_icb_cmd_read  (itcm_icb_cmd_read),
        .itcm_icb_cmd_wdata (itcm_icb_cmd_wdata),
        .itcm_icb_cmd_wmask (itcm_icb_cmd_wmask),
        .itcm_icb_rsp_valid (itcm_icb_rsp_valid),
        .itcm_icb_rsp_ready (itcm_icb_rsp_ready),
        .itcm_icb_rsp_err   (itcm_icb_rsp_err),
        .itcm_icb_rsp_rdata (itcm_icb_rsp_rdata),
        .arb_busy           (arb_busy)
    );

    typedef struct packed {
        logic [15:0] addr;
        logic        read;
    } cmd_t;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [32:0] ifu_q[$];
    logic [32:0] ldr_q[$];
    cmd_t        mdl_q[$];
    logic        rsp_en;

    logic [15:0] t2_ia [3] = '{16'h0010, 16'h0014, 16'h0018};
    logic [15:0] t2_la [2] = '{16'h0200, 16'h0204};
    logic        t2_g  [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};  // 1 = loader

    // ITCM memory model: reads return {addr^5A5A, addr}, writes return 0,
    // addresses 0xExxx respond with an error.
    function automatic logic [32:0] exp_rsp(input logic [15:0] a, input logic rd);
        logic        e;
        logic [31:0] d;
        e = (a[15:12] == 4'hE);
        d = rd ? {a ^ 16'h5A5A, a} : 32'h0;
        return {e, d};
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ifu_icb_cmd_valid = 1'b0;
        ldr_icb_cmd_valid = 1'b0;
        ifu_q.delete();
        ldr_q.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 40; i++) begin
            if (ifu_q.size() == 0 && ldr_q.size() == 0) break;
            @(posedge clk);
            #3;
        end
        check(name, 64'(ifu_q.size() + ldr_q.size()), 64'd0);
    endtask

    // In-order ITCM slave: one-cycle response latency, gated by rsp_en.
    initial begin
        logic c_hs;
        logic r_hs;
        cmd_t c;
        itcm_icb_rsp_valid = 1'b0;
        itcm_icb_rsp_err   = 1'b0;
        itcm_icb_rsp_rdata = '0;
        forever begin
            @(negedge clk);
            c_hs   = itcm_icb_cmd_valid && itcm_icb_cmd_ready;
            c.addr = itcm_icb_cmd_addr;
            c.read = itcm_icb_cmd_read;
            r_hs   = itcm_icb_rsp_valid && itcm_icb_rsp_ready;
            @(posedge clk);
            if (rst) begin
                mdl_q.delete();
            end else begin
                if (r_hs && mdl_q.size() > 0) void'(mdl_q.pop_front());
                if (c_hs) mdl_q.push_back(c);
            end
            #2;
            itcm_icb_rsp_valid = rsp_en && (mdl_q.size() > 0);
            if (mdl_q.size() > 0) begin
                {itcm_icb_rsp_err, itcm_icb_rsp_rdata} = exp_rsp(mdl_q[0].addr, mdl_q[0].read);
            end else begin
                {itcm_icb_rsp_err, itcm_icb_rsp_rdata} = '0;
            end
        end
    end

    // Response monitor: compares each delivered response with its scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (ifu_icb_rsp_valid && ifu_icb_rsp_ready) begin
                    if (ifu_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL ifu_rsp_unexpected: got rdata %0h, expected none",
                                 ifu_icb_rsp_rdata);
                    end else begin
                        check("ifu_rsp", {ifu_icb_rsp_err, ifu_icb_rsp_rdata}, ifu_q.pop_front());
                    end
                    check("ldr_quiet_on_ifu_rsp",
                          {ldr_icb_rsp_valid, ldr_icb_rsp_err, ldr_icb_rsp_rdata}, 64'd0);
                end
                if (ldr_icb_rsp_valid && ldr_icb_rsp_ready) begin
                    if (ldr_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL ldr_rsp_unexpected: got rdata %0h, expected none",
                                 ldr_icb_rsp_rdata);
                    end else begin
                        check("ldr_rsp", {ldr_icb_rsp_err, ldr_icb_rsp_rdata}, ldr_q.pop_front());
                    end
                    check("ifu_quiet_on_ldr_rsp",
                          {ifu_icb_rsp_valid, ifu_icb_rsp_err, ifu_icb_rsp_rdata}, 64'd0);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ii;
        int li;
        rst                = 1'b1;
        ifu_icb_cmd_valid  = 1'b0;
        ifu_icb_cmd_addr   = '0;
        ifu_icb_rsp_ready  = 1'b1;
        ldr_icb_cmd_valid  = 1'b0;
        ldr_icb_cmd_addr   = '0;
        ldr_icb_cmd_read   = 1'b1;
        ldr_icb_cmd_wdata  = 32'hCAFEF00D;
        ldr_icb_cmd_wmask  = 4'hF;
        ldr_icb_rsp_ready  = 1'b1;
        itcm_icb_cmd_ready = 1'b1;
        rsp_en             = 1'b1;

        // Reset state
        do_reset();
        @(negedge clk);
        check("reset_outputs",
              {itcm_icb_cmd_valid, itcm_icb_rsp_ready, ifu_icb_rsp_valid, ldr_icb_rsp_valid,
               arb_busy, ifu_icb_cmd_ready, ldr_icb_cmd_ready, itcm_icb_cmd_addr,
               itcm_icb_cmd_wmask, itcm_icb_cmd_wdata}, 64'd0);

        // IFU-only reads pass through in the same cycle
        tick();
        ifu_icb_cmd_valid = 1'b1;
        ifu_icb_cmd_addr  = 16'h0000;
        ifu_q.push_back(exp_rsp(16'h0000, 1'b1));
        @(negedge clk);
        check("t1_first",
              {ifu_icb_cmd_ready, ldr_icb_cmd_ready, itcm_icb_cmd_valid, itcm_icb_cmd_read,
               itcm_icb_cmd_addr, itcm_icb_cmd_wmask, itcm_icb_cmd_wdata},
              {1'b1, 1'b0, 1'b1, 1'b1, 16'h0000, 4'h0, 32'h0});
        tick();
        ifu_icb_cmd_addr = 16'h0004;
        ifu_q.push_back(exp_rsp(16'h0004, 1'b1));
        @(negedge clk);
        check("t1_second",
              {ifu_icb_cmd_ready, itcm_icb_cmd_valid, itcm_icb_cmd_read, itcm_icb_cmd_addr},
              {1'b1, 1'b1, 1'b1, 16'h0004});
        tick();
        ifu_icb_cmd_valid = 1'b0;
        wait_drain("t1_drain");

        // Round-robin alternation from reset with both requesters busy
        do_reset();
        ldr_icb_cmd_read = 1'b1;
        foreach (t2_ia[k]) ifu_q.push_back(exp_rsp(t2_ia[k], 1'b1));
        foreach (t2_la[k]) ldr_q.push_back(exp_rsp(t2_la[k], 1'b1));
        ii = 0;
        li = 0;
        for (int c = 0; c < 5; c++) begin
            ifu_icb_cmd_valid = (ii < 3);
            ifu_icb_cmd_addr  = (ii < 3) ? t2_ia[ii] : 16'h0;
            ldr_icb_cmd_valid = (li < 2);
            ldr_icb_cmd_addr  = (li < 2) ? t2_la[li] : 16'h0;
            @(negedge clk);
            if (t2_g[c]) begin
                check("t2_grant_ldr", {ifu_icb_cmd_ready, ldr_icb_cmd_ready, itcm_icb_cmd_addr},
                      {1'b0, 1'b1, t2_la[li]});
            end else begin
                check("t2_grant_ifu", {ifu_icb_cmd_ready, ldr_icb_cmd_ready, itcm_icb_cmd_addr},
                      {1'b1, 1'b0, t2_ia[ii]});
            end
            tick();
            if (t2_g[c]) li++;
            else ii++;
        end
        ifu_icb_cmd_valid = 1'b0;
        ldr_icb_cmd_valid = 1'b0;
        wait_drain("t2_drain");

        // Loader write stalled by the ITCM: lock holds the grant
        do_reset();
        itcm_icb_cmd_ready = 1'b0;
        ldr_icb_cmd_valid  = 1'b1;
        ldr_icb_cmd_addr   = 16'h0100;
        ldr_icb_cmd_read   = 1'b0;
        ldr_icb_cmd_wdata  = 32'hDEADBEEF;
        ldr_icb_cmd_wmask  = 4'hF;
        ldr_q.push_back(exp_rsp(16'h0100, 1'b0));
        for (int c = 0; c < 3; c++) begin
            if (c == 1) begin
                ifu_icb_cmd_valid = 1'b1;
                ifu_icb_cmd_addr  = 16'h0020;
                ifu_q.push_back(exp_rsp(16'h0020, 1'b1));
            end
            @(negedge clk);
            check("t3_stall",
                  {itcm_icb_cmd_valid, itcm_icb_cmd_read, itcm_icb_cmd_addr, itcm_icb_cmd_wdata,
                   itcm_icb_cmd_wmask, ifu_icb_cmd_ready, ldr_icb_cmd_ready, arb_busy},
                  {1'b1, 1'b0, 16'h0100, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 1'b1});
            tick();
        end
        itcm_icb_cmd_ready = 1'b1;
        @(negedge clk);
        check("t3_accept", {ldr_icb_cmd_ready, ifu_icb_cmd_ready, itcm_icb_cmd_addr},
              {1'b1, 1'b0, 16'h0100});
        tick();
        ldr_icb_cmd_valid = 1'b0;
        ldr_icb_cmd_read  = 1'b1;
        @(negedge clk);
        check("t3_ifu_next",
              {ifu_icb_cmd_ready, itcm_icb_cmd_valid, itcm_icb_cmd_read, itcm_icb_cmd_addr,
               itcm_icb_cmd_wmask}, {1'b1, 1'b1, 1'b1, 16'h0020, 4'h0});
        tick();
        ifu_icb_cmd_valid = 1'b0;
        wait_drain("t3_drain");

        // Outstanding limit: third command waits for the first response pop
        tick();
        rsp_en            = 1'b0;
        ifu_icb_cmd_valid = 1'b1;
        ifu_icb_cmd_addr  = 16'h0030;
        ifu_q.push_back(exp_rsp(16'h0030, 1'b1));
        @(negedge clk);
        check("t4_acc0", 64'(ifu_icb_cmd_ready), 64'd1);
        tick();
        ifu_icb_cmd_addr = 16'h0034;
        ifu_q.push_back(exp_rsp(16'h0034, 1'b1));
        @(negedge clk);
        check("t4_acc1", 64'(ifu_icb_cmd_ready), 64'd1);
        tick();
        ifu_icb_cmd_addr = 16'h0038;
        ifu_q.push_back(exp_rsp(16'h0038, 1'b1));
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("t4_full", {ifu_icb_cmd_ready, itcm_icb_cmd_valid, arb_busy},
                  {1'b0, 1'b0, 1'b1});
            tick();
        end
        rsp_en = 1'b1;
        @(negedge clk);
        check("t4_pop_cycle", {ifu_icb_cmd_ready, ifu_icb_rsp_valid}, {1'b0, 1'b1});
        tick();
        @(negedge clk);
        check("t4_freed", {ifu_icb_cmd_ready, itcm_icb_cmd_valid, itcm_icb_cmd_addr},
              {1'b1, 1'b1, 16'h0038});
        tick();
        ifu_icb_cmd_valid = 1'b0;
        wait_drain("t4_drain");

        // Error response on a loader read
        tick();
        ldr_icb_cmd_valid = 1'b1;
        ldr_icb_cmd_addr  = 16'hE010;
        ldr_icb_cmd_read  = 1'b1;
        ldr_q.push_back(exp_rsp(16'hE010, 1'b1));
        @(negedge clk);
        check("t5_acc", 64'(ldr_icb_cmd_ready), 64'd1);
        tick();
        ldr_icb_cmd_valid = 1'b0;
        wait_drain("t5_drain");
        check("t5_idle", {arb_busy, itcm_icb_rsp_ready}, 64'd0);

        // Reset with a command outstanding and the lock held
        tick();
        rsp_en            = 1'b0;
        ifu_icb_cmd_valid = 1'b1;
        ifu_icb_cmd_addr  = 16'h0040;
        ifu_q.push_back(exp_rsp(16'h0040, 1'b1));
        tick();
        ifu_icb_cmd_valid  = 1'b0;
        ldr_icb_cmd_valid  = 1'b1;
        ldr_icb_cmd_addr   = 16'h0104;
        ldr_icb_cmd_read   = 1'b0;
        itcm_icb_cmd_ready = 1'b0;
        @(negedge clk);
        check("t6_locking", {itcm_icb_cmd_valid, ldr_icb_cmd_ready}, {1'b1, 1'b0});
        tick();
        @(negedge clk);
        check("t6_locked", {arb_busy, itcm_icb_cmd_valid, itcm_icb_cmd_addr},
              {1'b1, 1'b1, 16'h0104});
        tick();
        itcm_icb_cmd_ready = 1'b1;
        do_reset();
        @(negedge clk);
        check("t6_post_rst",
              {arb_busy, itcm_icb_cmd_valid, ifu_icb_rsp_valid, ldr_icb_rsp_valid,
               itcm_icb_rsp_ready}, 64'd0);
        tick();
        rsp_en            = 1'b1;
        ifu_icb_cmd_valid = 1'b1;
        ifu_icb_cmd_addr  = 16'h0044;
        ldr_icb_cmd_valid = 1'b1;
        ldr_icb_cmd_addr  = 16'h0108;
        ldr_icb_cmd_read  = 1'b1;
        ifu_q.push_back(exp_rsp(16'h0044, 1'b1));
        ldr_q.push_back(exp_rsp(16'h0108, 1'b1));
        @(negedge clk);
        check("t6_tie_ifu", {ifu_icb_cmd_ready, ldr_icb_cmd_ready, itcm_icb_cmd_addr},
              {1'b1, 1'b0, 16'h0044});
        tick();
        ifu_icb_cmd_valid = 1'b0;
        @(negedge clk);
        check("t6_ldr_next", {ldr_icb_cmd_ready, itcm_icb_cmd_addr}, {1'b1, 16'h0108});
        tick();
        ldr_icb_cmd_valid = 1'b0;
        wait_drain("t6_drain");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
